// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: mode encodings, default underrun fill and clog2.
package spi_pkg;

  // Modes are encoded as {CPOL, CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic [31:0] TX_FILL_DEFAULT = '1;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } frame_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy, full/empty flags and a sticky overflow flag.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic [clog2(DEPTH):0]    level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int AW  = clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FULL_LVL = AW1'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (push_i && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/spi_slave_fifo.sv
// Oversampled SPI slave, all four modes, parametrised word width, MISO words sourced from a TX FIFO.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int            DW          = 8,
  parameter bit            CPOL        = 1'b0,
  parameter bit            CPHA        = 1'b0,
  parameter int            TX_DEPTH    = 4,
  parameter int            SYNC_STAGES = 2,
  parameter logic [DW-1:0] TX_FILL     = TX_FILL_DEFAULT[DW-1:0]
) (
  input  logic                       clk6x,
  input  logic                       reset,
  input  logic                       spi_clk_i,
  input  logic                       spi_csn_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  output logic                       spi_miso_drive_o,
  output logic [DW-1:0]              rx_byte_o,
  output logic                       rx_hdr_en_o,
  output logic                       rx_db_en_o,
  input  logic [DW-1:0]              tx_byte_i,
  input  logic                       tx_en_i,
  output logic [clog2(TX_DEPTH):0]   tx_level_o,
  output logic                       tx_full_o,
  output logic                       tx_underrun_o,
  output logic                       tx_overflow_o
);

  localparam int CW = clog2(DW);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
  localparam bit SAMPLE_LEAD = ({CPOL, CPHA} == MODE0) || ({CPOL, CPHA} == MODE2);

  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sck_last_q;
  logic                   sck_s, csn_s, mosi_s;
  logic                   edge_any, lead_edge, trail_edge, sample_edge, launch_edge;

  frame_state_e state_q, state_d;
  logic         frame_start, frame_end;

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic [DW-1:0] rx_byte_q, rx_byte_d;
  logic          miso_q, miso_d;
  logic          first_word_q, first_word_d;
  logic          word_done_q, word_done_d;
  logic          hdr_q, hdr_d, db_q, db_d;
  logic          underrun_q, underrun_d;
  logic          pend_q, pend_d;
  logic          pend_empty_q, pend_empty_d;

  logic          fifo_pop, fifo_empty;
  logic [DW-1:0] fifo_head, load_word;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk6x),
    .reset      (reset),
    .push_i     (tx_en_i),
    .data_i     (tx_byte_i),
    .pop_i      (fifo_pop),
    .data_o     (fifo_head),
    .level_o    (tx_level_o),
    .full_o     (tx_full_o),
    .empty_o    (fifo_empty),
    .overflow_o (tx_overflow_o)
  );

  always_ff @(posedge clk6x) begin
    if (reset) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_last_q  <= CPOL;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_last_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign edge_any    = (sck_s != sck_last_q) && (state_q == ST_ACTIVE) && !csn_s;
  assign lead_edge   = edge_any && (sck_s != CPOL);
  assign trail_edge  = edge_any && (sck_s == CPOL);
  assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
  assign launch_edge = SAMPLE_LEAD ? trail_edge : lead_edge;
  assign load_word   = fifo_empty ? TX_FILL : fifo_head;

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: if (!csn_s) begin
        state_d     = ST_ACTIVE;
        frame_start = 1'b1;
      end
      ST_ACTIVE: if (csn_s) begin
        state_d   = ST_IDLE;
        frame_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // With CPHA=0 the next word's MSB must be on MISO before its first sample
  // edge, but after the last word the master still produces a trailing edge.
  // So the head is only presented there and popped at the word's first sample
  // edge, which keeps a frame from consuming a reply it never clocks out.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    rx_byte_d    = rx_byte_q;
    miso_d       = miso_q;
    first_word_d = first_word_q;
    word_done_d  = 1'b0;
    hdr_d        = 1'b0;
    db_d         = 1'b0;
    underrun_d   = 1'b0;
    pend_d       = pend_q;
    pend_empty_d = pend_empty_q;
    fifo_pop     = 1'b0;

    if (word_done_q) begin
      rx_byte_d    = rx_shift_q;
      hdr_d        = first_word_q;
      db_d         = !first_word_q;
      first_word_d = 1'b0;
    end

    if (frame_start) begin
      first_word_d = 1'b1;
      bit_cnt_d    = '0;
      if (!CPHA) begin
        tx_shift_d   = load_word;
        miso_d       = load_word[DW-1];
        pend_d       = 1'b1;
        pend_empty_d = fifo_empty;
      end
    end else if (frame_end) begin
      bit_cnt_d = '0;
      pend_d    = 1'b0;
    end else begin
      if (sample_edge) begin
        rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d   = '0;
          word_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
        if (pend_q && (bit_cnt_q == '0)) begin
          pend_d     = 1'b0;
          underrun_d = pend_empty_q;
          fifo_pop   = !pend_empty_q;
        end
      end
      if (launch_edge) begin
        if (bit_cnt_q == '0) begin
          tx_shift_d = load_word;
          miso_d     = load_word[DW-1];
          if (CPHA) begin
            underrun_d = fifo_empty;
            fifo_pop   = !fifo_empty;
          end else begin
            pend_d       = 1'b1;
            pend_empty_d = fifo_empty;
          end
        end else begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[DW-2];
        end
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      rx_byte_q    <= '0;
      miso_q       <= 1'b1;
      first_word_q <= 1'b0;
      word_done_q  <= 1'b0;
      hdr_q        <= 1'b0;
      db_q         <= 1'b0;
      underrun_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      rx_byte_q    <= rx_byte_d;
      miso_q       <= miso_d;
      first_word_q <= first_word_d;
      word_done_q  <= word_done_d;
      hdr_q        <= hdr_d;
      db_q         <= db_d;
      underrun_q   <= underrun_d;
      pend_q       <= pend_d;
      pend_empty_q <= pend_empty_d;
    end
  end

  assign spi_miso_o       = miso_q;
  assign spi_miso_drive_o = !csn_s;
  assign rx_byte_o        = rx_byte_q;
  assign rx_hdr_en_o      = hdr_q;
  assign rx_db_en_o       = db_q;
  assign tx_underrun_o    = underrun_q;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: one instance per SPI mode, a bit-level master model and a strobe scoreboard.
module tb_spi_slave_fifo;
  import spi_pkg::*;

  localparam time CLK_HALF = 5ns;
  localparam time HALF     = 81ns;
  localparam logic [1:0] MODES [4] = '{MODE0, MODE1, MODE2, MODE3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       sck [4];
  logic       csn [4];
  logic       tx_en [4];
  logic       miso [4];
  logic       miso_drv [4];
  logic [7:0] rx_byte [4];
  logic       hdr [4];
  logic       db [4];
  logic [2:0] tx_level [4];
  logic       tx_full [4];
  logic       underrun [4];
  logic       ovf [4];

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance FIFO contents, sticky overflow, expected underruns, expected RX strobes.
  logic [7:0] model_q [4][$];
  logic       model_ovf [4];
  int         exp_und [4];
  int         und_cnt [4];
  logic [8:0] rx_exp [4][$];
  logic [7:0] fw [8];
  logic [8:0] e;

  always #CLK_HALF clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_fifo #(
      .DW          (8),
      .CPOL        (MODES[g][1]),
      .CPHA        (MODES[g][0]),
      .TX_DEPTH    (4),
      .SYNC_STAGES (2),
      .TX_FILL     (8'hFF)
    ) u_dut (
      .clk6x            (clk),
      .reset            (reset),
      .spi_clk_i        (sck[g]),
      .spi_csn_i        (csn[g]),
      .spi_mosi_i       (mosi),
      .spi_miso_o       (miso[g]),
      .spi_miso_drive_o (miso_drv[g]),
      .rx_byte_o        (rx_byte[g]),
      .rx_hdr_en_o      (hdr[g]),
      .rx_db_en_o       (db[g]),
      .tx_byte_i        (tx_byte),
      .tx_en_i          (tx_en[g]),
      .tx_level_o       (tx_level[g]),
      .tx_full_o        (tx_full[g]),
      .tx_underrun_o    (underrun[g]),
      .tx_overflow_o    (ovf[g])
    );
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitor: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 4; m++) begin
        if (underrun[m]) und_cnt[m]++;
        if (hdr[m] || db[m]) begin
          if (rx_exp[m].size() == 0) begin
            chk($sformatf("m%0d unexpected strobe", m), {30'd0, hdr[m], db[m]}, 32'd0);
          end else begin
            e = rx_exp[m].pop_front();
            chk($sformatf("m%0d strobe kind", m), {30'd0, hdr[m], db[m]}, e[8] ? 32'd2 : 32'd1);
            chk($sformatf("m%0d rx word", m), {24'd0, rx_byte[m]}, {24'd0, e[7:0]});
          end
        end
      end
    end
  end

  task automatic push(input int m, input logic [7:0] v);
    @(negedge clk);
    tx_byte  = v;
    tx_en[m] = 1'b1;
    @(negedge clk);
    tx_en[m] = 1'b0;
    if (model_q[m].size() < 4) model_q[m].push_back(v);
    else model_ovf[m] = 1'b1;
  endtask

  task automatic check_fifo(input int m);
    @(negedge clk);
    chk($sformatf("m%0d level", m), {29'd0, tx_level[m]}, model_q[m].size());
    chk($sformatf("m%0d full", m), {31'd0, tx_full[m]}, {31'd0, model_q[m].size() == 4});
    chk($sformatf("m%0d overflow", m), {31'd0, ovf[m]}, {31'd0, model_ovf[m]});
    chk($sformatf("m%0d underruns", m), und_cnt[m], exp_und[m]);
  endtask

  // Master: nw whole words from fw[], then tail_bits of fw[nw] before CSN is dropped.
  task automatic frame(input int m, input int nw, input int tail_bits);
    logic [1:0] md;
    logic       cpol, cpha;
    logic [7:0] got, expw;
    int         total, nb;
    md    = MODES[m];
    cpol  = md[1];
    cpha  = md[0];
    total = nw + ((tail_bits > 0) ? 1 : 0);
    for (int w = 0; w < nw; w++) rx_exp[m].push_back({(w == 0), fw[w]});
    csn[m] = 1'b0;
    #HALF;
    for (int w = 0; w < total; w++) begin
      nb = (w < nw) ? 8 : tail_bits;
      if (model_q[m].size() > 0) expw = model_q[m].pop_front();
      else begin
        expw = 8'hFF;
        exp_und[m]++;
      end
      got = '0;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          mosi = fw[w][7-i];
          #HALF;
          sck[m] = ~cpol;
          got = {got[6:0], miso[m]};
          #HALF;
          sck[m] = cpol;
        end else begin
          sck[m] = ~cpol;
          mosi = fw[w][7-i];
          #HALF;
          sck[m] = cpol;
          got = {got[6:0], miso[m]};
          #HALF;
        end
      end
      if (nb == 8) chk($sformatf("m%0d miso word %0d", m, w), {24'd0, got}, {24'd0, expw});
    end
    #HALF;
    csn[m] = 1'b1;
    #(3 * HALF);
  endtask

  task automatic check_reset_values();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d rst miso", m), {31'd0, miso[m]}, 32'd1);
      chk($sformatf("m%0d rst drive", m), {31'd0, miso_drv[m]}, 32'd0);
      chk($sformatf("m%0d rst rx_byte", m), {24'd0, rx_byte[m]}, 32'd0);
      chk($sformatf("m%0d rst strobes", m), {30'd0, hdr[m], db[m]}, 32'd0);
      chk($sformatf("m%0d rst level", m), {29'd0, tx_level[m]}, 32'd0);
      chk($sformatf("m%0d rst flags", m), {29'd0, tx_full[m], underrun[m], ovf[m]}, 32'd0);
    end
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      sck[m] = MODES[m][1];
      csn[m] = 1'b1;
      tx_en[m] = 1'b0;
      model_ovf[m] = 1'b0;
      exp_und[m] = 0;
      und_cnt[m] = 0;
    end
    repeat (5) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Header then data words, FIFO empty so every reply is the fill word.
    fw[0] = 8'h01; fw[1] = 8'h20; fw[2] = 8'h80; fw[3] = 8'hA5; fw[4] = 8'hC4;
    frame(0, 5, 0);
    check_fifo(0);

    // Queued replies come back in order and drain the FIFO.
    push(0, 8'h55); push(0, 8'hAA); push(0, 8'h3C);
    check_fifo(0);
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
    frame(0, 3, 0);
    check_fifo(0);

    // Same exchange in every mode.
    for (int m = 0; m < 4; m++) begin
      push(m, 8'h5A);
      fw[0] = 8'hA5;
      frame(m, 1, 0);
      check_fifo(m);
    end

    // Empty FIFO, two words: two underruns.
    fw[0] = 8'hC3; fw[1] = 8'h3C;
    frame(0, 2, 0);
    check_fifo(0);

    // Overfill: fourth push fills, fifth is dropped and overflow sticks.
    for (int i = 0; i < 4; i++) push(1, 8'(8'h10 + i));
    check_fifo(1);
    push(1, 8'hEE);
    check_fifo(1);
    fw[0] = 8'h99; fw[1] = 8'h66;
    frame(1, 2, 0);
    check_fifo(1);

    // Aborted partial word, then a fresh frame reports its first word as header.
    fw[0] = 8'hB7;
    frame(0, 0, 3);
    fw[0] = 8'h7E;
    frame(0, 1, 0);
    check_fifo(0);

    // Randomised traffic across modes.
    for (int r = 0; r < 10; r++) begin
      int m, np, nw;
      m  = $urandom_range(0, 3);
      np = $urandom_range(0, 5);
      nw = $urandom_range(1, 4);
      for (int i = 0; i < np; i++) push(m, 8'($urandom));
      check_fifo(m);
      for (int i = 0; i < nw; i++) fw[i] = 8'($urandom);
      frame(m, nw, 0);
      check_fifo(m);
    end

    // Reset in the middle of a mode 0 frame with queued replies.
    push(0, 8'h81); push(0, 8'h42);
    csn[0] = 1'b0;
    #HALF; mosi = 1'b1;
    #HALF; sck[0] = 1'b1;
    #HALF; sck[0] = 1'b0;
    #HALF; sck[0] = 1'b1;
    #HALF;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    csn[0] = 1'b1;
    sck[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int m = 0; m < 4; m++) begin
      model_q[m].delete();
      model_ovf[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    fw[0] = 8'h3C;
    frame(0, 1, 0);
    check_fifo(0);

    for (int m = 0; m < 4; m++)
      chk($sformatf("m%0d strobes outstanding", m), rx_exp[m].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
